// File: rtl/spi_master_if.sv
// Bus-side signals of the memory-mapped SPI master: select, address, strobes, data and ready.
interface spi_master_if;
  logic        spi_sel;
  logic [3:0]  addr;
  logic [3:0]  wstrb;
  logic [31:0] spi_data_i;
  logic [31:0] spi_data_o;
  logic        spi_ready;

  modport master (
    output spi_sel, addr, wstrb, spi_data_i,
    input  spi_data_o, spi_ready
  );

  modport slave (
    input  spi_sel, addr, wstrb, spi_data_i,
    output spi_data_o, spi_ready
  );
endinterface

// File: rtl/spi_master.sv
// Polled SPI master (mode 0, 8-bit frames, MSB first) with DATA/CTRL registers on a simple valid/ready bus.
module spi_master #(
  parameter logic [7:0] DEFAULT_DIV = 8'd2
) (
  input  logic         clk,
  input  logic         reset,
  spi_master_if.slave  bus,
  output logic         sclk,
  output logic         mosi,
  input  logic         miso,
  output logic         cs_n
);

  typedef enum logic {IDLE, SHIFT} state_e;

  state_e      state_q, state_d;
  logic        ready_q;
  logic [31:0] rdata_q;
  logic        rxValid_q;
  logic [7:0]  rxData_q;
  logic [7:0]  div_q;
  logic        csBit_q;
  logic        csN_q;
  logic        sclk_q;
  logic        mosi_q;
  logic [7:0]  txShift_q;
  logic [7:0]  rxShift_q;
  logic [7:0]  frameDiv_q;
  logic [7:0]  cnt_q;
  logic [3:0]  tog_q;

  logic [1:0]  regSel;
  logic        isWrite;
  logic        busy;
  logic        stall;
  logic        accept;
  logic        startFrame;
  logic        tick;
  logic        lastToggle;
  logic [31:0] readData;
  logic        unusedData;

  assign regSel     = bus.addr[3:2];
  assign unusedData = ^bus.spi_data_i[31:9];

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (startFrame) state_d = SHIFT;
      SHIFT:   if (lastToggle) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Only DATA/CTRL writes that could disturb a running frame wait for it to finish.
  always_comb begin
    isWrite    = |bus.wstrb;
    busy       = (state_q == SHIFT);
    stall      = busy && isWrite && (((regSel == 2'd0) && bus.wstrb[0]) || (regSel == 2'd1));
    accept     = bus.spi_sel && !ready_q && !stall;
    startFrame = accept && (regSel == 2'd0) && bus.wstrb[0];
    tick       = busy && (cnt_q == frameDiv_q);
    lastToggle = tick && (tog_q == 4'd15);
    readData   = '0;
    case (regSel)
      2'd0:    readData = {24'b0, rxData_q};
      2'd1:    readData = {busy, rxValid_q, 21'b0, csBit_q, div_q};
      default: readData = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ready_q    <= 1'b0;
      rdata_q    <= '0;
      rxValid_q  <= 1'b0;
      rxData_q   <= '0;
      div_q      <= DEFAULT_DIV;
      csBit_q    <= 1'b0;
      csN_q      <= 1'b1;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      txShift_q  <= '0;
      rxShift_q  <= '0;
      frameDiv_q <= '0;
      cnt_q      <= '0;
      tog_q      <= '0;
    end else begin
      ready_q <= accept;
      if (accept) rdata_q <= isWrite ? 32'd0 : readData;

      if (accept && isWrite && (regSel == 2'd1)) begin
        if (bus.wstrb[0]) div_q <= bus.spi_data_i[7:0];
        if (bus.wstrb[1]) begin
          csBit_q <= bus.spi_data_i[8];
          csN_q   <= ~bus.spi_data_i[8];
        end
      end

      // Frame completion beats a coincident DATA read clearing the flag.
      if (lastToggle)                                     rxValid_q <= 1'b1;
      else if (accept && !isWrite && (regSel == 2'd0))    rxValid_q <= 1'b0;

      if (startFrame) begin
        txShift_q  <= bus.spi_data_i[7:0];
        mosi_q     <= bus.spi_data_i[7];
        sclk_q     <= 1'b0;
        frameDiv_q <= div_q;
        cnt_q      <= '0;
        tog_q      <= '0;
      end else if (busy) begin
        if (tick) begin
          cnt_q <= '0;
          tog_q <= tog_q + 4'd1;
          if (lastToggle) begin
            sclk_q   <= 1'b0;
            rxData_q <= rxShift_q;
          end else begin
            sclk_q <= ~sclk_q;
            if (!sclk_q) begin
              rxShift_q <= {rxShift_q[6:0], miso};
            end else begin
              mosi_q    <= txShift_q[6];
              txShift_q <= {txShift_q[6:0], 1'b0};
            end
          end
        end else begin
          cnt_q <= cnt_q + 8'd1;
        end
      end
    end
  end

  assign bus.spi_ready  = ready_q;
  assign bus.spi_data_o = rdata_q;
  assign sclk           = sclk_q;
  assign mosi           = mosi_q;
  assign cs_n           = csN_q;

endmodule

// File: tb/tb_spi_master.sv
// Scoreboard bench for spi_master: bus reads/handshake timing checked against queued expectations, SPI pins monitored.
module tb_spi_master;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic sclk, mosi, miso, cs_n;
  logic loopback = 1'b0;
  logic misoVal  = 1'b0;

  int   vectors     = 0;
  int   miscompares = 0;
  int   cycleCnt    = 0;
  int   riseCnt     = 0;
  logic [7:0] monByte = '0;
  exp_t sbQ[$];

  spi_master_if bus ();

  spi_master dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .sclk  (sclk),
    .mosi  (mosi),
    .miso  (miso),
    .cs_n  (cs_n)
  );

  assign miso = loopback ? mosi : misoVal;

  always #5 clk = ~clk;

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  // Captures the bit presented on mosi at each SCLK rising edge, i.e. what a slave would sample.
  always @(posedge sclk) begin
    riseCnt = riseCnt + 1;
    monByte = {monByte[6:0], mosi};
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  task automatic expectPush(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sbQ.push_back(e);
  endtask

  task automatic compareNext(input logic [31:0] actual);
    exp_t e;
    if (sbQ.size() > 0) begin
      e = sbQ.pop_front();
      checkOutput(e.tag, actual, e.val);
    end
  endtask

  // Called #1 after a clock edge; returns #1 after the edge on which ready has dropped again.
  task automatic busXfer(input logic [3:0] a, input logic [3:0] strb, input logic [31:0] wd,
                         output logic [31:0] rd, output int rdyCyc);
    bit seen;
    seen   = 1'b0;
    rd     = '0;
    rdyCyc = -1;
    bus.addr       = a;
    bus.wstrb      = strb;
    bus.spi_data_i = wd;
    bus.spi_sel    = 1'b1;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (bus.spi_ready) begin
        seen   = 1'b1;
        rd     = bus.spi_data_o;
        rdyCyc = cycleCnt;
      end
    end
    bus.spi_sel = 1'b0;
    bus.wstrb   = 4'b0000;
    if (!seen) checkOutput("handshake timeout", {31'b0, bus.spi_ready}, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] a, input logic [3:0] strb, input logic [31:0] wd,
                               output int rdyCyc);
    logic [31:0] rd;
    busXfer(a, strb, wd, rd, rdyCyc);
  endtask

  task automatic readExpect(input logic [3:0] a, input logic [31:0] expVal, input string tag);
    logic [31:0] rd;
    int          cyc;
    expectPush(tag, expVal);
    busXfer(a, 4'b0000, 32'h0, rd, cyc);
    compareNext(rd);
  endtask

  task automatic frameCheck(input string tag, input logic [7:0] expByte, input int base, input int pulses);
    checkOutput({tag, " pulses"}, riseCnt - base, pulses);
    checkOutput({tag, " mosi bits"}, {24'b0, monByte}, {24'b0, expByte});
  endtask

  initial begin
    int c0, c1, base;
    bus.spi_sel    = 1'b0;
    bus.addr       = '0;
    bus.wstrb      = '0;
    bus.spi_data_i = '0;
    reset          = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset sclk", {31'b0, sclk}, 32'd0);
    checkOutput("reset cs_n", {31'b0, cs_n}, 32'd1);
    checkOutput("reset mosi", {31'b0, mosi}, 32'd0);
    checkOutput("reset ready", {31'b0, bus.spi_ready}, 32'd0);
    checkOutput("reset data_o", bus.spi_data_o, 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    readExpect(4'h4, 32'h0000_0002, "reset ctrl");
    readExpect(4'h0, 32'h0000_0000, "reset data");
    readExpect(4'h8, 32'h0000_0000, "reserved read");

    $display("[TB] div=0 loopback frame 0xA5");
    applyStimulus(4'h4, 4'b0001, 32'h0, c0);
    loopback = 1'b1;
    base     = riseCnt;
    expectPush("busy div0", 32'd17);
    applyStimulus(4'h0, 4'b0001, 32'hA5, c0);
    applyStimulus(4'h4, 4'b0010, 32'h100, c1);
    compareNext(c1 - c0);
    checkOutput("cs_n low after ctrl", {31'b0, cs_n}, 32'd0);
    frameCheck("frame A5", 8'hA5, base, 8);
    checkOutput("mosi idle hold", {31'b0, mosi}, 32'd1);
    readExpect(4'h4, 32'h4000_0100, "ctrl rx_valid set");
    readExpect(4'h0, 32'h0000_00A5, "rx A5");
    readExpect(4'h4, 32'h0000_0100, "ctrl rx_valid cleared");

    $display("[TB] div=3 miso high frame 0x3C");
    applyStimulus(4'h4, 4'b0001, 32'h3, c0);
    loopback = 1'b0;
    misoVal  = 1'b1;
    base     = riseCnt;
    expectPush("busy div3", 32'd65);
    applyStimulus(4'h0, 4'b0001, 32'h3C, c0);
    applyStimulus(4'h4, 4'b0010, 32'h0, c1);
    compareNext(c1 - c0);
    checkOutput("cs_n high after ctrl", {31'b0, cs_n}, 32'd1);
    frameCheck("frame 3C", 8'h3C, base, 8);
    checkOutput("mosi idle hold 0", {31'b0, mosi}, 32'd0);
    readExpect(4'h0, 32'h0000_00FF, "rx FF");

    $display("[TB] back-to-back DATA writes");
    loopback = 1'b1;
    base     = riseCnt;
    expectPush("stall second data", 32'd65);
    applyStimulus(4'h0, 4'b0001, 32'h81, c0);
    applyStimulus(4'h0, 4'b0001, 32'h7E, c1);
    compareNext(c1 - c0);
    readExpect(4'h0, 32'h0000_0081, "rx between frames");
    readExpect(4'h4, 32'h8000_0003, "ctrl while busy");
    applyStimulus(4'h4, 4'b0010, 32'h100, c1);
    checkOutput("cs_n low cs-only write", {31'b0, cs_n}, 32'd0);
    frameCheck("frame 81+7E", 8'h7E, base, 16);
    readExpect(4'h4, 32'h4000_0103, "div unchanged");
    readExpect(4'h0, 32'h0000_007E, "rx 7E");
    applyStimulus(4'h4, 4'b0010, 32'h000, c1);
    checkOutput("cs_n high cs-only write", {31'b0, cs_n}, 32'd1);
    applyStimulus(4'h4, 4'b0010, 32'h100, c1);

    $display("[TB] reset mid-frame");
    base = riseCnt;
    expectPush("reserved write no stall", 32'd2);
    applyStimulus(4'h0, 4'b0001, 32'h55, c0);
    applyStimulus(4'hC, 4'b1111, 32'hFFFF_FFFF, c1);
    compareNext(c1 - c0);
    for (int i = 0; i < 2000 && (riseCnt - base) < 4; i++) begin
      @(posedge clk);
      #1;
    end
    if ((riseCnt - base) != 4) checkOutput("rise 4 wait", riseCnt - base, 32'd4);
    reset = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("abort sclk", {31'b0, sclk}, 32'd0);
    checkOutput("abort cs_n", {31'b0, cs_n}, 32'd1);
    reset = 1'b0;
    @(posedge clk);
    #1;
    readExpect(4'h4, 32'h0000_0002, "abort ctrl");
    readExpect(4'h0, 32'h0000_0000, "abort rx_data");

    $display("[TB] frame after reset");
    base = riseCnt;
    expectPush("busy div2", 32'd49);
    applyStimulus(4'h0, 4'b0001, 32'hC3, c0);
    applyStimulus(4'h4, 4'b0010, 32'h0, c1);
    compareNext(c1 - c0);
    frameCheck("frame C3", 8'hC3, base, 8);
    readExpect(4'h0, 32'h0000_00C3, "rx C3");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/spi_master.md
Name: spi_master

Overview:
- Memory-mapped SPI master (mode 0, 8-bit frames) on the picorv32 native bus, one slave beside the UART and timer.
- Decoded in the SoC top at 80000020–8000002F; the top drives spi_sel from mem_valid plus address match and ORs spi_ready into mem_ready.
- Intended for SPI flash or sensor access from firmware by polled register access. No interrupt.

Parameters:
- DEFAULT_DIV, 8'd2: reset value of CTRL.div. SCLK half-period is H = div+1 clk cycles.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- spi_sel  input  1  slave select (mem_valid && address hit); held until spi_ready
- addr  input  4  byte address within block; [3:2] selects register
- wstrb  input  4  byte-lane write enables; 0 = read
- spi_data_i  input  32  write data
- spi_data_o  output  32  read data, valid while spi_ready=1
- spi_ready  output  1  transaction complete
- sclk  output  1  SPI clock, idle low
- mosi  output  1  SPI data out, MSB first
- miso  input  1  SPI data in
- cs_n  output  1  chip select, active low, software controlled

Behaviour:
- Reset values, applied on the clk edge with reset=1:
  - Outputs: spi_ready=0, spi_data_o=0, sclk=0, mosi=0, cs_n=1.
  - Internal: busy=0, rx_valid=0, rx_data=0, div=DEFAULT_DIV, cs_bit=0.
  - Reset mid-transfer aborts the frame immediately with the same values. There is no partial rx update.
- Register map (addr[3:2]):
  - 0 DATA
    - Write with wstrb[0] loads spi_data_i[7:0] and starts a frame.
    - Read returns {24'b0, rx_data} and clears rx_valid.
  - 1 CTRL
    - Write: wstrb[0] sets div <= spi_data_i[7:0]; wstrb[1] sets cs_bit <= spi_data_i[8].
    - Read returns {busy, rx_valid, 21'b0, cs_bit, div}.
  - 2, 3 reserved: read 0, writes ignored, normal ready.
- cs_n = ~cs_bit, registered. It updates the cycle after the CTRL write is accepted.
- Bus handshake:
  - Reads: spi_ready asserts exactly 1 cycle after spi_sel rises, with spi_data_o valid. It deasserts the following cycle.
  - spi_ready never asserts two consecutive cycles. A new transaction may begin the cycle after ready drops.
  - Writes to DATA or CTRL while busy=1 stall: spi_ready stays 0 until the cycle after busy falls. The write is then accepted and ready pulses.
  - Writes to reserved registers, and writes with wstrb[0]=0 to DATA, never stall.
  - Reads never stall. A DATA read during busy returns the previous rx_data.
- Frame FSM, states IDLE -> SHIFT -> IDLE:
  - On DATA accept: tx_sh <= byte, mosi <= byte[7], sclk=0, div latched into div_q, counters cleared, busy=1.
  - In SHIFT, sclk toggles every H = div_q+1 cycles, for 16 toggles total.
  - Rising edge: sample miso into rx_sh LSB (shift left).
  - Falling edge (edges 1–7): mosi <= next tx bit.
  - After the 16th toggle (8th falling edge): sclk=0, rx_data <= rx_sh, rx_valid=1, busy=0, return to IDLE.
  - busy is high for exactly 16*H cycles.
- Arithmetic and edge cases:
  - div is 8 bits, so H ranges 1..256. div=0 gives sclk = clk/2.
  - A CTRL.div change takes effect at the next frame start only.
  - A new frame overwrites rx_data even if rx_valid=1; there is no overrun flag.
  - A DATA read completing on the same cycle a frame ends: the clear loses and rx_valid ends 1.
  - mosi holds its last bit in IDLE.

Test Plan:
- Reset -> CTRL reads 0x00000002. cs_n=1, sclk=0, spi_ready=0. DATA reads 0.
- div=0, mosi looped to miso, write DATA=0xA5 -> sclk shows 8 pulses, busy=1 for exactly 16 cycles, then DATA reads 0xA5 and CTRL bit30 clears after that read.
- div=3, miso tied 1, write 0x3C -> busy 64 cycles. mosi bits 0,0,1,1,1,1,0,0 are each stable across a rising edge. rx_data=0xFF.
- Second DATA write issued 2 cycles after the first -> spi_ready stays low until the cycle after busy falls. The second frame starts then, and the first rx_data is visible between frames.
- CTRL write 0x100 with wstrb=4'b0010 -> cs_n=0 next cycle, div unchanged. Write 0x000 with wstrb=4'b0010 -> cs_n=1.
- reset asserted at toggle 7 of a frame -> next cycle sclk=0, cs_n=1, busy=0, rx_valid=0, rx_data=0. A subsequent frame completes normally.
